de_morgan_checker: RTL and testbench



---
 rtl/de_morgan_pkg.sv | 23 ++
 rtl/de_morgan_checker_if.sv | 26 ++
 rtl/de_morgan_ref.sv | 14 +
 rtl/de_morgan_checker.sv | 103 ++++++++++
 tb/tb_de_morgan_checker.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/de_morgan_pkg.sv
// Shared types, constants and the reference function for the De Morgan gate checker.
package de_morgan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MODE_NAND_FORM = 0;
  localparam int unsigned MODE_NOR_FORM  = 1;
  localparam int unsigned IDX_W          = 8;
  localparam int unsigned COV_W          = 4;

  localparam logic [IDX_W-1:0] NO_ERR_IDX = 8'hFF;

  // Expected gate output: NAND form ~(a&b) or NOR form ~(a|b).
  function automatic logic ref_out(input int unsigned mode, input logic a, input logic b);
    if (mode == MODE_NOR_FORM) return ~(a | b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/de_morgan_checker_if.sv
// Sample strobe and result bus between the lab stimulus and the checker.
interface de_morgan_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             valid;
  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       first_err_idx;
  logic [3:0]       coverage;

  modport master (
    output start, valid, a, b, c,
    input  busy, done, pass, err_cnt, first_err_idx, coverage
  );

  modport slave (
    input  start, valid, a, b, c,
    output busy, done, pass, err_cnt, first_err_idx, coverage
  );
endinterface

// File: rtl/de_morgan_ref.sv
// Combinational reference model of the gate under test.
module de_morgan_ref
  import de_morgan_pkg::*;
#(
  parameter int unsigned MODE = MODE_NAND_FORM
) (
  input  logic a,
  input  logic b,
  output logic expected_c
);

  always_comb expected_c = ref_out(MODE, a, b);

endmodule

// File: rtl/de_morgan_checker.sv
// Response checker: compares strobed gate samples against the reference, counts
// mismatches, records the first failing index and tracks {a,b} coverage.
module de_morgan_checker
  import de_morgan_pkg::*;
#(
  parameter int unsigned SAMPLE_COUNT = 16,
  parameter int unsigned ERR_W        = 8,
  parameter int unsigned MODE         = MODE_NAND_FORM
) (
  input  logic                clk,
  input  logic                rst,
  de_morgan_checker_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   first_q, first_d;
  logic [COV_W-1:0]   cov_q, cov_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               expected_c;
  logic               mismatch_c;

  de_morgan_ref #(.MODE(MODE)) u_ref (
    .a          (bus.a),
    .b          (bus.b),
    .expected_c (expected_c)
  );

  assign mismatch_c = (bus.c != expected_c);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    cov_d   = cov_q;
    pass_d  = pass_q;

    unique case (state_q)
      RUN: begin
        if (bus.valid) begin
          cov_d[{bus.a, bus.b}] = 1'b1;
          if (mismatch_c) begin
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
            if (first_q == NO_ERR_IDX)  first_d = cnt_q;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(SAMPLE_COUNT - 1)) begin
            state_d = DONE;
            pass_d  = (err_d == '0) && (cov_d == 4'b1111);
          end
        end
      end
      default: begin
        // IDLE and DONE: start wins over any coincident sample
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          err_d   = '0;
          first_d = NO_ERR_IDX;
          cov_d   = '0;
          pass_d  = 1'b0;
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= NO_ERR_IDX;
      cov_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      cov_q   <= cov_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_idx = first_q;
  assign bus.coverage      = cov_q;

endmodule

// File: tb/tb_de_morgan_checker.sv
// Directed bench for de_morgan_checker: four parameterisations, a per-instance
// model and a scoreboard of end-of-run results.
module tb_de_morgan_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  de_morgan_checker_if #(.ERR_W(8)) if0 ();
  de_morgan_checker_if #(.ERR_W(2)) if1 ();
  de_morgan_checker_if #(.ERR_W(8)) if2 ();
  de_morgan_checker_if #(.ERR_W(8)) if3 ();

  de_morgan_checker #(.SAMPLE_COUNT(4), .ERR_W(8), .MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  de_morgan_checker #(.SAMPLE_COUNT(6), .ERR_W(2), .MODE(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  de_morgan_checker #(.SAMPLE_COUNT(4), .ERR_W(8), .MODE(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  de_morgan_checker #(.SAMPLE_COUNT(1), .ERR_W(8), .MODE(0)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [7:0] first;
    logic [3:0] cov;
  } obs_t;

  typedef struct {
    int         sel;
    int         err;
    int         first;
    int         cov;
    int         pass;
  } exp_t;

  exp_t sb_q[$];

  int sc_a[4]   = '{4, 6, 4, 1};
  int emax_a[4] = '{255, 3, 255, 255};
  int mode_a[4] = '{0, 0, 1, 0};

  // Model state: 0 idle, 1 run, 2 done
  int m_state[4];
  int m_cnt[4];
  int m_err[4];
  int m_first[4];
  int m_cov[4];
  int m_pass[4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    o = '0;
    case (sel)
      0: o = '{if0.busy, if0.done, if0.pass, 8'(if0.err_cnt), if0.first_err_idx, if0.coverage};
      1: o = '{if1.busy, if1.done, if1.pass, 8'(if1.err_cnt), if1.first_err_idx, if1.coverage};
      2: o = '{if2.busy, if2.done, if2.pass, 8'(if2.err_cnt), if2.first_err_idx, if2.coverage};
      default: o = '{if3.busy, if3.done, if3.pass, 8'(if3.err_cnt), if3.first_err_idx, if3.coverage};
    endcase
    return o;
  endfunction

  task automatic model_clear(input int sel);
    m_state[sel] = 0;
    m_cnt[sel]   = 0;
    m_err[sel]   = 0;
    m_first[sel] = 255;
    m_cov[sel]   = 0;
    m_pass[sel]  = 0;
  endtask

  task automatic model_step(input int sel, input logic st, input logic v,
                            input logic a, input logic b, input logic c);
    logic e;
    if (m_state[sel] == 1) begin
      if (v) begin
        e = (mode_a[sel] == 1) ? ~(a | b) : ~(a & b);
        if (c !== e) begin
          if (m_err[sel] < emax_a[sel]) m_err[sel]++;
          if (m_first[sel] == 255) m_first[sel] = m_cnt[sel];
        end
        m_cov[sel] = m_cov[sel] | (1 << (int'(a) * 2 + int'(b)));
        m_cnt[sel]++;
        if (m_cnt[sel] == sc_a[sel]) begin
          m_state[sel] = 2;
          m_pass[sel]  = (m_err[sel] == 0 && m_cov[sel] == 15) ? 1 : 0;
          sb_q.push_back('{sel, m_err[sel], m_first[sel], m_cov[sel], m_pass[sel]});
        end
      end
    end else if (st) begin
      model_clear(sel);
      m_state[sel] = 1;
    end
  endtask

  // Drive one cycle of stimulus to the selected instance; the others see no strobes.
  task automatic drive(input int sel, input logic st, input logic v,
                       input logic a, input logic b, input logic c);
    @(negedge clk);
    if0.start = (sel == 0) && st; if0.valid = (sel == 0) && v;
    if1.start = (sel == 1) && st; if1.valid = (sel == 1) && v;
    if2.start = (sel == 2) && st; if2.valid = (sel == 2) && v;
    if3.start = (sel == 3) && st; if3.valid = (sel == 3) && v;
    if0.a = a; if0.b = b; if0.c = c;
    if1.a = a; if1.b = b; if1.c = c;
    if2.a = a; if2.b = b; if2.c = c;
    if3.a = a; if3.b = b; if3.c = c;
    @(posedge clk);
    #1;
    model_step(sel, st, v, a, b, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if0.start = 1'b0; if0.valid = 1'b0;
    if1.start = 1'b0; if1.valid = 1'b0;
    if2.start = 1'b0; if2.valid = 1'b0;
    if3.start = 1'b0; if3.valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_clear(i);
  endtask

  task automatic check_live(input int sel, input string tag);
    obs_t o;
    o = get_obs(sel);
    chk({tag, " busy"},  32'(o.busy),  32'(m_state[sel] == 1));
    chk({tag, " done"},  32'(o.done),  32'(m_state[sel] == 2));
    chk({tag, " pass"},  32'(o.pass),  32'(m_pass[sel]));
    chk({tag, " err"},   32'(o.err),   32'(m_err[sel]));
    chk({tag, " first"}, 32'(o.first), 32'(m_first[sel]));
    chk({tag, " cov"},   32'(o.cov),   32'(m_cov[sel]));
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    obs_t o;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s sb: observed empty scoreboard expected one result", tag);
    end else begin
      e = sb_q.pop_front();
      o = get_obs(e.sel);
      chk({tag, " sb done"},  32'(o.done),  32'd1);
      chk({tag, " sb busy"},  32'(o.busy),  32'd0);
      chk({tag, " sb err"},   32'(o.err),   32'(e.err));
      chk({tag, " sb first"}, 32'(o.first), 32'(e.first));
      chk({tag, " sb cov"},   32'(o.cov),   32'(e.cov));
      chk({tag, " sb pass"},  32'(o.pass),  32'(e.pass));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    obs_t o;
    logic [1:0] ab;
    {if0.start, if0.valid, if0.a, if0.b, if0.c} = '0;
    {if1.start, if1.valid, if1.a, if1.b, if1.c} = '0;
    {if2.start, if2.valid, if2.a, if2.b, if2.c} = '0;
    {if3.start, if3.valid, if3.a, if3.b, if3.c} = '0;
    for (int i = 0; i < 4; i++) model_clear(i);

    do_reset();
    for (int i = 0; i < 4; i++) check_live(i, "reset");
    o = get_obs(0);
    chk("reset first", 32'(o.first), 32'h0FF);

    // All four combinations, correct NAND-form responses
    drive(0, 1, 0, 0, 0, 0);
    check_live(0, "A start");
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 1, 1);
    drive(0, 0, 1, 1, 0, 1);
    check_live(0, "A s3");
    drive(0, 0, 1, 1, 1, 0);
    check_done("A");
    o = get_obs(0);
    chk("A pass", 32'(o.pass), 32'd1);
    chk("A cov", 32'(o.cov), 32'hF);

    // Restart from DONE; sample 2 ({a,b}=10) answered wrongly
    drive(0, 1, 0, 0, 0, 0);
    check_live(0, "B start");
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 1, 0, 1, 1);
    drive(0, 0, 1, 1, 0, 0);
    check_live(0, "B s3");
    drive(0, 0, 1, 1, 1, 0);
    check_done("B");
    o = get_obs(0);
    chk("B err", 32'(o.err), 32'd1);
    chk("B first", 32'(o.first), 32'd2);

    // Coverage hole: only {0,0} and {0,1}
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 1, 1);
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 1, 1);
    check_done("C");
    o = get_obs(0);
    chk("C cov", 32'(o.cov), 32'h3);
    chk("C pass", 32'(o.pass), 32'd0);

    // Every response inverted on a 2-bit counter: saturation at 3
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      ab = 2'(i % 4);
      drive(1, 0, 1, ab[1], ab[0], ab[1] & ab[0]);
      if (i == 2) check_live(1, "D s3");
    end
    check_done("D");
    o = get_obs(1);
    chk("D err", 32'(o.err), 32'd3);
    chk("D first", 32'(o.first), 32'd0);

    // Single-sample run
    drive(3, 1, 1, 0, 0, 0);
    check_live(3, "E start");
    drive(3, 0, 1, 1, 1, 0);
    check_done("E");
    o = get_obs(3);
    chk("E cov", 32'(o.cov), 32'h8);
    chk("E pass", 32'(o.pass), 32'd0);

    // Reset mid-run, then strobes without start are ignored
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 1);
    check_live(0, "F mid");
    do_reset();
    check_live(0, "F rst");
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 1, 0);
    check_live(0, "F ign");
    o = get_obs(0);
    chk("F cov", 32'(o.cov), 32'h0);

    // NOR form, then start+valid in DONE discards that sample
    drive(2, 1, 0, 0, 0, 0);
    drive(2, 0, 1, 0, 0, 1);
    drive(2, 0, 1, 0, 1, 0);
    drive(2, 0, 1, 1, 0, 0);
    drive(2, 0, 1, 1, 1, 0);
    check_done("G1");
    o = get_obs(2);
    chk("G1 pass", 32'(o.pass), 32'd1);
    drive(2, 1, 1, 1, 1, 1);
    check_live(2, "G restart");
    o = get_obs(2);
    chk("G restart busy", 32'(o.busy), 32'd1);
    chk("G restart err", 32'(o.err), 32'd0);
    drive(2, 0, 1, 1, 1, 0);
    drive(2, 0, 1, 1, 0, 0);
    drive(2, 0, 1, 0, 1, 0);
    check_live(2, "G s3");
    drive(2, 0, 1, 0, 0, 1);
    check_done("G2");
    o = get_obs(2);
    chk("G2 pass", 32'(o.pass), 32'd1);

    chk("sb drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
